regfile_wb_ctrl: RTL and testbench

Writeback controller that drives the write port (wa/wd/we) of the 64 x 32 register file. It accepts write requests from two producers, the ALU and the load unit, through valid/ready handshakes and buffers one request per source. It arbitrates round-robin and issues at most one register-file write per cycle. A pending-write scoreboard tells the issue stage which source registers still have an outstanding write.

---
 rtl/regfile_wb_ctrl_pkg.sv | 13 +
 rtl/regfile_wb_ctrl_if.sv | 34 +++
 rtl/regfile_wb_ctrl_slot.sv | 32 +++
 rtl/regfile_wb_ctrl.sv | 78 +++++++
 tb/tb_regfile_wb_ctrl.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared register-file types: widths, writeback request record and source ids.
package regfile_pkg;
  localparam int RWIDTH = 6;
  localparam int DWIDTH = 32;
  localparam int NREGS  = 2 ** RWIDTH;

  typedef struct packed {
    logic [RWIDTH-1:0] wa;
    logic [DWIDTH-1:0] wd;
  } wb_req_t;

  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;
endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Producer, issue-stage and register-file write-port signals of the writeback controller.
interface regfile_wb_ctrl_if;
  import regfile_pkg::*;

  logic              alu_valid;
  logic              alu_ready;
  logic [RWIDTH-1:0] alu_wa;
  logic [DWIDTH-1:0] alu_wd;
  logic              mem_valid;
  logic              mem_ready;
  logic [RWIDTH-1:0] mem_wa;
  logic [DWIDTH-1:0] mem_wd;
  logic              claim_valid;
  logic [RWIDTH-1:0] claim_wa;
  logic [RWIDTH-1:0] ra1;
  logic [RWIDTH-1:0] ra2;
  logic              busy1;
  logic              busy2;
  logic              we;
  logic [RWIDTH-1:0] wa;
  logic [DWIDTH-1:0] wd;

  modport master (
    output alu_valid, alu_wa, alu_wd, mem_valid, mem_wa, mem_wd,
           claim_valid, claim_wa, ra1, ra2,
    input  alu_ready, mem_ready, busy1, busy2, we, wa, wd
  );

  modport slave (
    input  alu_valid, alu_wa, alu_wd, mem_valid, mem_wa, mem_wd,
           claim_valid, claim_wa, ra1, ra2,
    output alu_ready, mem_ready, busy1, busy2, we, wa, wd
  );
endinterface

// File: rtl/regfile_wb_ctrl_slot.sv
// One-entry request buffer; popping and refilling on the same edge keeps streaming gap-free.
module wb_slot
  import regfile_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    valid,
  output logic    ready,
  input  wb_req_t req,
  input  logic    pop,
  output logic    full,
  output wb_req_t entry
);
  logic    full_reg;
  wb_req_t entry_reg;

  assign ready = !rst && (!full_reg || pop);
  assign full  = full_reg;
  assign entry = entry_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      full_reg  <= 1'b0;
      entry_reg <= '0;
    end else if (valid && ready) begin
      full_reg  <= 1'b1;
      entry_reg <= req;
    end else if (pop) begin
      full_reg  <= 1'b0;
    end
  end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: two buffered producers, round-robin write issue and a
// pending-write scoreboard for the issue stage.
module regfile_wb_ctrl
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  regfile_wb_ctrl_if.slave  bus
);
  logic       alu_full, mem_full;
  wb_req_t    alu_entry, mem_entry, alu_req, mem_req, grant_entry;
  logic       grant_alu, grant_mem;
  src_e       last_grant_reg;
  logic [NREGS-1:0]  pend_reg;
  logic              we_reg;
  logic [RWIDTH-1:0] wa_reg;
  logic [DWIDTH-1:0] wd_reg;

  assign alu_req = '{wa: bus.alu_wa, wd: bus.alu_wd};
  assign mem_req = '{wa: bus.mem_wa, wd: bus.mem_wd};

  wb_slot u_alu_slot (
    .clk(clk), .rst(rst), .valid(bus.alu_valid), .ready(bus.alu_ready),
    .req(alu_req), .pop(grant_alu), .full(alu_full), .entry(alu_entry)
  );

  wb_slot u_mem_slot (
    .clk(clk), .rst(rst), .valid(bus.mem_valid), .ready(bus.mem_ready),
    .req(mem_req), .pop(grant_mem), .full(mem_full), .entry(mem_entry)
  );

  // On a tie the source that did not win last time takes the port.
  assign grant_alu   = alu_full && (!mem_full || last_grant_reg == SRC_MEM);
  assign grant_mem   = mem_full && (!alu_full || last_grant_reg == SRC_ALU);
  assign grant_entry = grant_alu ? alu_entry : mem_entry;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= SRC_ALU;
      we_reg         <= 1'b0;
      wa_reg         <= '0;
      wd_reg         <= '0;
    end else begin
      if (grant_alu)      last_grant_reg <= SRC_ALU;
      else if (grant_mem) last_grant_reg <= SRC_MEM;

      if (grant_alu || grant_mem) begin
        we_reg <= (grant_entry.wa != '0);
        wa_reg <= grant_entry.wa;
        wd_reg <= grant_entry.wd;
      end else begin
        we_reg <= 1'b0;
      end
    end
  end

  // Bit 0 never sets since r0 is never written; a claim beats a same-edge clear.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_pend
      always_ff @(posedge clk) begin
        if (rst) begin
          pend_reg[gi] <= 1'b0;
        end else if (bus.claim_valid && bus.claim_wa == RWIDTH'(gi) && gi != 0) begin
          pend_reg[gi] <= 1'b1;
        end else if (we_reg && wa_reg == RWIDTH'(gi)) begin
          pend_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign bus.busy1 = (bus.ra1 != '0) && (pend_reg[bus.ra1] || (we_reg && wa_reg == bus.ra1));
  assign bus.busy2 = (bus.ra2 != '0) && (pend_reg[bus.ra2] || (we_reg && wa_reg == bus.ra2));

  assign bus.we = we_reg;
  assign bus.wa = wa_reg;
  assign bus.wd = wd_reg;
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: latency, contention order, r0 drop, scoreboard and reset.
module tb_regfile_wb_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  regfile_wb_ctrl_if bus();

  regfile_wb_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 0; bus.alu_wa = 0; bus.alu_wd = 0;
    bus.mem_valid = 0; bus.mem_wa = 0; bus.mem_wd = 0;
    bus.claim_valid = 0; bus.claim_wa = 0;
  endtask

  // Advance one edge; inputs are then driven 1 after it and outputs read 2 after it.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ai, mi, wi;
    logic a_acc, m_acc;
    logic [5:0] exp_order [8];
    exp_order[0] = 11; exp_order[1] = 1; exp_order[2] = 12; exp_order[3] = 2;
    exp_order[4] = 13; exp_order[5] = 3; exp_order[6] = 14; exp_order[7] = 4;

    idle_inputs();
    bus.ra1 = 0; bus.ra2 = 0;
    rst = 1;
    next_cycle(); next_cycle();
    #1;
    check("rst_alu_ready", bus.alu_ready, 0);
    check("rst_mem_ready", bus.mem_ready, 0);
    rst = 0;
    next_cycle(); #1;
    check("rst_we", bus.we, 0);
    check("rst_wa", bus.wa, 0);
    check("rst_wd", bus.wd, 0);

    // Single ALU write: two edges from accept to we.
    bus.alu_valid = 1; bus.alu_wa = 5; bus.alu_wd = 32'hDEADBEEF; #1;
    check("single_ready", bus.alu_ready, 1);
    next_cycle(); idle_inputs(); #1;
    check("single_we_n1", bus.we, 0);
    next_cycle(); #1;
    check("single_we", bus.we, 1);
    check("single_wa", bus.wa, 5);
    check("single_wd", bus.wd, 32'hDEADBEEF);
    next_cycle(); #1;
    check("single_we_off", bus.we, 0);

    // Contention: both streaming, expect M,A alternation starting with MEM.
    ai = 0; mi = 0; wi = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      bus.alu_valid = (ai < 4); bus.alu_wa = 6'(1 + ai);  bus.alu_wd = 32'(32'h100 + 1 + ai);
      bus.mem_valid = (mi < 4); bus.mem_wa = 6'(11 + mi); bus.mem_wd = 32'(32'h100 + 11 + mi);
      #1;
      a_acc = bus.alu_valid && bus.alu_ready;
      m_acc = bus.mem_valid && bus.mem_ready;
      if (cyc >= 1 && cyc <= 6) check("cont_ready_alt", bus.alu_ready ^ bus.mem_ready, 1);
      if (bus.we) begin
        if (wi < 8) begin
          check("cont_wa", bus.wa, exp_order[wi]);
          check("cont_wd", bus.wd, 32'h100 + 32'(exp_order[wi]));
        end
        wi++;
      end
      next_cycle();
      if (a_acc) ai++;
      if (m_acc) mi++;
    end
    check("cont_count", wi, 8);
    idle_inputs();

    // r0 write: accepted and dropped, next request follows without a gap.
    bus.mem_valid = 1; bus.mem_wa = 0; bus.mem_wd = 32'h1234; #1;
    check("r0_ready", bus.mem_ready, 1);
    next_cycle();
    bus.mem_wa = 3; bus.mem_wd = 32'h33; #1;
    check("r0_next_ready", bus.mem_ready, 1);
    next_cycle(); idle_inputs(); #1;
    check("r0_we", bus.we, 0);
    next_cycle(); #1;
    check("r0_next_we", bus.we, 1);
    check("r0_next_wa", bus.wa, 3);
    next_cycle();

    // Scoreboard: claim 7, write 7, busy until the capture edge.
    bus.ra1 = 7; bus.ra2 = 0;
    bus.claim_valid = 1; bus.claim_wa = 7; #1;
    check("sb_busy_pre", bus.busy1, 0);
    next_cycle(); idle_inputs();
    bus.alu_valid = 1; bus.alu_wa = 7; bus.alu_wd = 32'h77; #1;
    check("sb_busy_claimed", bus.busy1, 1);
    check("sb_busy2_r0", bus.busy2, 0);
    next_cycle(); idle_inputs(); #1;
    check("sb_busy_grant", bus.busy1, 1);
    next_cycle(); #1;
    check("sb_we7", bus.we && bus.wa == 7, 1);
    check("sb_busy_we", bus.busy1, 1);
    next_cycle(); #1;
    check("sb_busy_clear", bus.busy1, 0);
    check("sb_busy2_r0_end", bus.busy2, 0);

    // Claim and clear of reg 9 on the same edge: set wins.
    bus.ra1 = 9;
    bus.claim_valid = 1; bus.claim_wa = 9;
    bus.alu_valid = 1; bus.alu_wa = 9; bus.alu_wd = 32'h99;
    next_cycle(); idle_inputs();
    next_cycle(); #1;
    check("coll_we9", bus.we && bus.wa == 9, 1);
    bus.claim_valid = 1; bus.claim_wa = 9;
    next_cycle(); idle_inputs(); #1;
    check("coll_pend9", bus.busy1, 1);
    next_cycle(); #1;
    check("coll_pend9_hold", bus.busy1, 1);

    // Reset mid-stream with both slots full and pend[9] set.
    bus.alu_valid = 1; bus.alu_wa = 20; bus.alu_wd = 32'h20;
    bus.mem_valid = 1; bus.mem_wa = 21; bus.mem_wd = 32'h21;
    next_cycle(); idle_inputs();
    rst = 1; #1;
    check("mrst_alu_ready", bus.alu_ready, 0);
    check("mrst_mem_ready", bus.mem_ready, 0);
    next_cycle();
    rst = 0; #1;
    check("mrst_we", bus.we, 0);
    check("mrst_wa", bus.wa, 0);
    check("mrst_wd", bus.wd, 0);
    check("mrst_busy", bus.busy1, 0);
    check("mrst_alu_ready_after", bus.alu_ready, 1);
    check("mrst_mem_ready_after", bus.mem_ready, 1);
    next_cycle(); #1;
    check("mrst_no_write", bus.we, 0);
    next_cycle(); #1;
    check("mrst_no_write2", bus.we, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
